// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch unit: a single-outstanding-read FSM that feeds decode through a valid/ready handshake.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirects; otherwise redirect targets are word-aligned.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_en,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_rd_addr,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_rd_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_fetch_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FLUSH,
    S_TRAP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        capture;
  logic        redirect_take;

  // Redirects are ignored only once trapped; this also lets a HOLD transfer complete alongside a redirect.
  assign redirect_take = i_redirect_valid && (state != S_TRAP);

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_fetch_en) state_next = S_REQ;
      end
      S_REQ: begin
        // An outstanding read always completes; i_fetch_en only gates the next request.
        if (i_mem_rd_valid) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_instr_ready) begin
          pc_next    = pc + 32'd4;
          state_next = i_fetch_en ? S_REQ : S_IDLE;
        end
      end
      S_FLUSH: begin
        state_next = i_fetch_en ? S_REQ : S_IDLE;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Redirect overrides the sequential PC and discards any read data returning this cycle.
    if (redirect_take) begin
      capture = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i_redirect_pc[1:0] != 2'b00) begin
        state_next = S_TRAP;
      end else begin
        pc_next    = i_redirect_pc;
        state_next = S_FLUSH;
      end
`else
      pc_next    = {i_redirect_pc[31:2], 2'b00};
      state_next = S_FLUSH;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      // NOTE: the instruction holding registers are reset too, so decode never sees stale data after reset.
      o_instr    <= 32'h0000_0000;
      o_instr_pc <= 32'h0000_0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture) begin
        o_instr    <= i_mem_rd_data;
        o_instr_pc <= pc;
      end
    end
  end

  assign o_mem_rd_en   = (state == S_REQ);
  assign o_mem_rd_addr = pc;
  assign o_instr_valid = (state == S_HOLD);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      misaligned <= 1'b0;
    end else if (redirect_take && (i_redirect_pc[1:0] != 2'b00)) begin
      misaligned <= 1'b1;
    end
  end

  assign o_fetch_misaligned = misaligned;
`else
  logic unused_redirect_lsbs;

  // Low target bits are dropped by the alignment above; this only keeps them visibly consumed.
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign o_fetch_misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: 3-cycle memory model, scoreboard of expected fetch PCs, scenario tasks.
// Build with FETCH_MISALIGN_TRAP_EN defined to exercise the trap variant of the misaligned-redirect scenario.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_fetch_en;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_mem_rd_en;
  logic [31:0] o_mem_rd_addr;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_rd_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        o_fetch_misaligned;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          xfer_t[$];
  logic        stray_valid = 1'b0;

  always #5 i_clk = ~i_clk;

  rv32i_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_fetch_en         (i_fetch_en),
    .i_redirect_valid   (i_redirect_valid),
    .i_redirect_pc      (i_redirect_pc),
    .o_mem_rd_en        (o_mem_rd_en),
    .o_mem_rd_addr      (o_mem_rd_addr),
    .i_mem_rd_data      (i_mem_rd_data),
    .i_mem_rd_valid     (i_mem_rd_valid),
    .o_instr            (o_instr),
    .o_instr_pc         (o_instr_pc),
    .o_instr_valid      (o_instr_valid),
    .i_instr_ready      (i_instr_ready),
    .o_fetch_misaligned (o_fetch_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Memory: valid on the 3rd consecutive cycle of read enable; stray_valid injects an unsolicited strobe.
  int en_cnt = 0;
  always @(negedge i_clk) begin
    #1;
    if (i_rst || !o_mem_rd_en) en_cnt = 0;
    else en_cnt = en_cnt + 1;
    if (en_cnt == 3) begin
      i_mem_rd_valid = 1'b1;
      i_mem_rd_data  = mem_word(o_mem_rd_addr);
    end else begin
      i_mem_rd_valid = stray_valid;
      i_mem_rd_data  = stray_valid ? 32'hDEAD_DEAD : 32'h0000_0000;
    end
  end

  // Monitor: address stability, valid latency, and scoreboard pop on each transfer.
  int          mon_cyc = 0;
  int          req_start = 0;
  logic        prev_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_pc;
  always @(negedge i_clk) begin
    #2;
    mon_cyc = mon_cyc + 1;
    if (i_rst) begin
      prev_en    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (o_mem_rd_en && !prev_en) req_start = mon_cyc;
      if (o_mem_rd_en && prev_en) begin
        total++;
        if (o_mem_rd_addr !== prev_addr) begin
          bad++;
          $display("FAIL addr_stable: got=%h want=%h", o_mem_rd_addr, prev_addr);
        end
      end
      if (o_instr_valid && !prev_valid) begin
        total++;
        if (mon_cyc - req_start != 3) begin
          bad++;
          $display("FAIL valid_latency: got=%0d want=3", mon_cyc - req_start);
        end
      end
      if (o_instr_valid && i_instr_ready) begin
        xfer_t.push_back(mon_cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_xfer: got pc=%h want none", o_instr_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          if (o_instr_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
            bad++;
            $display("FAIL xfer: got pc=%h instr=%h want pc=%h instr=%h",
                     o_instr_pc, o_instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      prev_en    = o_mem_rd_en;
      prev_valid = o_instr_valid;
      prev_addr  = o_mem_rd_addr;
    end
  end

  // Keep fetching until the last expected instruction is in flight, then stop and let it retire.
  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 || (exp_q.size() == 1 && o_mem_rd_en)) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    i_fetch_en = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    repeat (2) @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_instr_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    total++;
    if (!o_instr_valid) begin
      bad++;
      $display("FAIL %s_timeout: got valid=0 want 1", name);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_fetch_en = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc = 32'h0;
    i_instr_ready = 1'b1;
    i_mem_rd_valid = 1'b0;
    i_mem_rd_data = 32'h0;
    repeat (2) @(negedge i_clk);
    #1;
    total++;
    if (o_mem_rd_en !== 1'b0 || o_mem_rd_addr !== RESET_PC || o_instr_valid !== 1'b0 ||
        o_instr !== 32'h0 || o_instr_pc !== 32'h0 || o_fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got en=%b addr=%h v=%b instr=%h pc=%h mis=%b want 0 %h 0 0 0 0",
               o_mem_rd_en, o_mem_rd_addr, o_instr_valid, o_instr, o_instr_pc, o_fetch_misaligned, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    @(negedge i_clk);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    xfer_t.delete();
    i_rst = 1'b0;
    i_fetch_en = 1'b1;
    drain();
    total++;
    if (xfer_t.size() != 3) begin
      bad++;
      $display("FAIL seq_count: got=%0d want=3", xfer_t.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (xfer_t[i] - xfer_t[i-1] != 4) begin
          bad++;
          $display("FAIL seq_rate: got=%0d want=4", xfer_t[i] - xfer_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_hold_stall();
    exp_q.push_back(32'h10C);
    exp_q.push_back(32'h110);
    i_instr_ready = 1'b0;
    i_fetch_en = 1'b1;
    wait_valid("hold");
    repeat (10) begin
      @(negedge i_clk);
      #1;
      total++;
      if (!o_instr_valid || o_mem_rd_en || o_instr_pc !== 32'h10C || o_instr !== mem_word(32'h10C)) begin
        bad++;
        $display("FAIL hold_stable: got v=%b en=%b pc=%h instr=%h want 1 0 %h %h",
                 o_instr_valid, o_mem_rd_en, o_instr_pc, o_instr, 32'h10C, mem_word(32'h10C));
      end
    end
    i_instr_ready = 1'b1;
    drain();
  endtask

  task automatic test_redirect_req();
    exp_q.push_back(32'h200);
    @(negedge i_clk);
    stray_valid = 1'b1;
    @(negedge i_clk);
    stray_valid = 1'b0;
    #1;
    total++;
    if (o_instr_valid || o_mem_rd_en) begin
      bad++;
      $display("FAIL idle_stray: got v=%b en=%b want 0 0", o_instr_valid, o_mem_rd_en);
    end
    i_fetch_en = 1'b1;
    @(negedge i_clk);
    #1;
    total++;
    if (!o_mem_rd_en || o_mem_rd_addr !== 32'h114) begin
      bad++;
      $display("FAIL req_entry: got en=%b addr=%h want 1 00000114", o_mem_rd_en, o_mem_rd_addr);
    end
    @(negedge i_clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h200;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    stray_valid = 1'b1;
    #1;
    total++;
    if (o_mem_rd_en || o_instr_valid) begin
      bad++;
      $display("FAIL flush_req: got en=%b v=%b want 0 0", o_mem_rd_en, o_instr_valid);
    end
    @(negedge i_clk);
    stray_valid = 1'b0;
    #1;
    total++;
    if (!o_mem_rd_en || o_mem_rd_addr !== 32'h200) begin
      bad++;
      $display("FAIL redirect_addr: got en=%b addr=%h want 1 00000200", o_mem_rd_en, o_mem_rd_addr);
    end
    drain();
  endtask

  task automatic test_redirect_on_valid();
    exp_q.push_back(32'h240);
    @(negedge i_clk);
    i_fetch_en = 1'b1;
    repeat (3) @(negedge i_clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h240;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    #1;
    total++;
    if (o_mem_rd_en || o_instr_valid) begin
      bad++;
      $display("FAIL discard_data: got en=%b v=%b want 0 0", o_mem_rd_en, o_instr_valid);
    end
    drain();
  endtask

  task automatic test_back_to_back_redirect();
    exp_q.push_back(32'h244);
    exp_q.push_back(32'h300);
    @(negedge i_clk);
    i_fetch_en = 1'b1;
    @(negedge i_clk);
    wait_valid("xfer_redirect");
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h300;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    #1;
    total++;
    if (o_instr_valid || o_mem_rd_en || exp_q.size() != 1) begin
      bad++;
      $display("FAIL xfer_redirect: got v=%b en=%b pending=%0d want 0 0 1",
               o_instr_valid, o_mem_rd_en, exp_q.size());
    end
    @(negedge i_clk);
    #1;
    total++;
    if (!o_mem_rd_en || o_mem_rd_addr !== 32'h300) begin
      bad++;
      $display("FAIL xfer_redirect_addr: got en=%b addr=%h want 1 00000300", o_mem_rd_en, o_mem_rd_addr);
    end
    drain();
  endtask

  task automatic test_wrap();
    @(negedge i_clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    #1;
    total++;
    if (o_mem_rd_en || o_mem_rd_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_setup: got en=%b addr=%h want 0 fffffffc", o_mem_rd_en, o_mem_rd_addr);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    @(negedge i_clk);
    i_fetch_en = 1'b1;
    drain();
  endtask

  task automatic test_misaligned();
`ifdef FETCH_MISALIGN_TRAP_EN
    logic any_activity;
    @(negedge i_clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h202;
    i_fetch_en = 1'b1;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    #1;
    total++;
    if (o_fetch_misaligned !== 1'b1 || o_mem_rd_en || o_instr_valid) begin
      bad++;
      $display("FAIL trap_entry: got mis=%b en=%b v=%b want 1 0 0", o_fetch_misaligned, o_mem_rd_en, o_instr_valid);
    end
    @(negedge i_clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h400;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    any_activity = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      #1;
      if (o_mem_rd_en || o_instr_valid || !o_fetch_misaligned) any_activity = 1'b1;
    end
    total++;
    if (any_activity) begin
      bad++;
      $display("FAIL trap_sticky: got activity=1 want 0");
    end
    i_fetch_en = 1'b0;
`else
    exp_q.push_back(32'h200);
    @(negedge i_clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h202;
    i_fetch_en = 1'b1;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    #1;
    total++;
    if (o_fetch_misaligned !== 1'b0 || o_mem_rd_en) begin
      bad++;
      $display("FAIL misalign_flush: got mis=%b en=%b want 0 0", o_fetch_misaligned, o_mem_rd_en);
    end
    @(negedge i_clk);
    #1;
    total++;
    if (!o_mem_rd_en || o_mem_rd_addr !== 32'h200) begin
      bad++;
      $display("FAIL misalign_addr: got en=%b addr=%h want 1 00000200", o_mem_rd_en, o_mem_rd_addr);
    end
    drain();
`endif
  endtask

  task automatic test_reset_mid_read();
    logic any_activity;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_instr_ready = 1'b0;
    i_fetch_en = 1'b1;
    @(negedge i_clk);
    wait_valid("rst_hold");
    i_rst = 1'b1;
    #1;
    total++;
    if (o_instr_valid || o_mem_rd_en || o_instr !== 32'h0 || o_instr_pc !== 32'h0 ||
        o_mem_rd_addr !== RESET_PC || o_fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b en=%b instr=%h pc=%h addr=%h mis=%b want 0 0 0 0 %h 0",
               o_instr_valid, o_mem_rd_en, o_instr, o_instr_pc, o_mem_rd_addr, o_fetch_misaligned, RESET_PC);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    i_instr_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    total++;
    if (o_mem_rd_en || o_mem_rd_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_mid_read: got en=%b addr=%h want 0 %h", o_mem_rd_en, o_mem_rd_addr, RESET_PC);
    end
    i_fetch_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    any_activity = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      #1;
      if (o_mem_rd_en || o_instr_valid) any_activity = 1'b1;
    end
    total++;
    if (any_activity) begin
      bad++;
      $display("FAIL abandoned_read: got activity=1 want 0");
    end
    exp_q.push_back(32'h100);
    i_fetch_en = 1'b1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_req();
    test_redirect_on_valid();
    test_back_to_back_redirect();
    test_wrap();
    test_misaligned();
    test_reset_mid_read();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_end: got pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
